adder_issue_ctrl: RTL and testbench

Issue/capture controller that sits directly upstream of the registered ripple-carry adder (`adder_nb`) and also collects its result. It takes operand pairs over a valid/ready interface and drives the adder's operands and enable. It holds those operands stable for a fixed settle window, then captures the sum and carry. The result is presented on a valid/ready output, which gives the attention datapath a handshaked adder that never samples a partially rippled result.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_issue_ctrl.sv | 118 +++++++++++
 tb/tb_adder_issue_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the registered adder and its issue/capture controller.
package adder_pkg;

    localparam int ADDER_DW = 16;

    // Enough cycles for a full carry ripple through the adder, plus margin.
    function automatic int adder_settle_cycles(input int dw);
        return 2 * dw + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } adder_issue_state_e;

endpackage

// File: rtl/adder_issue_ctrl.sv
// Issue/capture controller for the registered ripple adder: latches an operand pair,
// holds the adder enabled for a settle window, then presents the captured sum/carry.
module adder_issue_ctrl
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH    = ADDER_DW,
    parameter int SETTLE_CYCLES = adder_settle_cycles(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_a,
    input  logic [DATA_WIDTH-1:0] s_b,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_ebl,
    input  logic [DATA_WIDTH-1:0] add_sum,
    input  logic                  add_carry,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_sum,
    output logic                  m_carry,
    output logic                  busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("adder_issue_ctrl: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    adder_issue_state_e r_state;
    adder_issue_state_e w_state_next;
    logic                  w_accept;
    logic                  w_capture;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_add_a;
    logic [DATA_WIDTH-1:0] r_add_b;
    logic [DATA_WIDTH-1:0] r_m_sum;
    logic                  r_m_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs decode only the state register, never s_valid/m_ready.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        s_ready      = 1'b0;
        add_ebl      = 1'b0;
        m_valid      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                add_ebl = 1'b1;
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_m_sum   <= '0;
            r_m_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_add_a <= s_a;
                r_add_b <= s_b;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_m_sum   <= add_sum;
                r_m_carry <= add_carry;
            end
        end
    end

    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign m_sum   = r_m_sum;
    assign m_carry = r_m_carry;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Directed bench for adder_issue_ctrl with a registered adder model beside it.
module tb_adder_issue_ctrl;

    localparam int DW = 16;
    localparam int SC = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_a = '0;
    logic [DW-1:0] s_b = '0;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_ebl;
    logic [DW-1:0] add_sum;
    logic          add_carry;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_sum;
    logic          m_carry;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_issue_ctrl #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .add_a(add_a), .add_b(add_b), .add_ebl(add_ebl),
        .add_sum(add_sum), .add_carry(add_carry),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_carry(m_carry),
        .busy(busy)
    );

    // Registered adder stand-in, reset active-high from !rst_n as the parent wires it.
    logic adder_rst;
    assign adder_rst = !rst_n;
    always_ff @(posedge clk or posedge adder_rst) begin
        if (adder_rst) begin
            {add_carry, add_sum} <= '0;
        end else if (add_ebl) begin
            {add_carry, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
        end
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] sum;
        logic          carry;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        s_a = a;
        s_b = b;
        s_valid = 1'b1;
        chk("s_ready_before_accept", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns at the negedge where m_valid is first seen.
    task automatic wait_result(input string name, output int lat, output int ebl_cnt);
        bit ok;
        ok = 1'b0;
        lat = 0;
        ebl_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            if (add_ebl) ebl_cnt++;
            lat++;
        end
        chk({name, "_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic check_result(input string name, input logic [DW-1:0] es, input logic ec);
        chk({name, "_sum"}, {16'b0, m_sum}, {16'b0, es});
        chk({name, "_carry"}, {31'b0, m_carry}, {31'b0, ec});
        chk({name, "_ebl_low_in_hold"}, {31'b0, add_ebl}, 32'd0);
    endtask

    int lat, ebl_cnt, seen;
    bit stable;

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h4321, sum: 16'h5555, carry: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sum: 16'h0000, carry: 1'b1};
        vecs[2] = '{a: 16'h0000, b: 16'h0000, sum: 16'h0000, carry: 1'b0};
        vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, sum: 16'hFFFE, carry: 1'b1};
        vecs[4] = '{a: 16'h8000, b: 16'h7FFF, sum: 16'hFFFF, carry: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_add_ebl", {31'b0, add_ebl}, 32'd0);
        chk("rst_outs", {add_a, add_b}, 32'd0);
        chk("rst_result", {15'b0, m_carry, m_sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single operations with m_ready high
        for (int i = 0; i < 5; i++) begin
            do_accept(vecs[i].a, vecs[i].b);
            wait_result("vec", lat, ebl_cnt);
            chk("vec_latency", lat, SC);
            chk("vec_ebl_cycles", ebl_cnt, SC);
            check_result("vec", vecs[i].sum, vecs[i].carry);
            chk("vec_busy_in_hold", {31'b0, busy}, 32'd1);
            @(negedge clk);
            chk("vec_idle_after_handshake", {30'b0, s_ready, m_valid}, 32'd2);
        end

        // m_ready held low for 10 cycles in HOLD
        m_ready = 1'b0;
        do_accept(16'hA5A5, 16'h0F0F);
        wait_result("hold", lat, ebl_cnt);
        check_result("hold", 16'hB4B4, 1'b0);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!m_valid || s_ready || m_sum !== 16'hB4B4 || m_carry !== 1'b0) stable = 1'b0;
        end
        chk("hold_stable", {31'b0, stable}, 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_idle", {30'b0, s_ready, m_valid}, 32'd2);

        // s_valid raised during SETTLE is ignored until IDLE
        do_accept(16'h00FF, 16'h0001);
        repeat (6) @(negedge clk);
        s_a = 16'h0001;
        s_b = 16'h0001;
        s_valid = 1'b1;
        wait_result("ign", lat, ebl_cnt);
        chk("ign_latency", lat, SC - 6);
        chk("ign_ops_frozen", {add_a, add_b}, {16'h00FF, 16'h0001});
        check_result("ign", 16'h0100, 1'b0);
        @(negedge clk);
        chk("ign_back_to_idle", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        chk("ign_second_accepted", {add_a, add_b}, {16'h0001, 16'h0001});
        chk("ign_second_busy", {31'b0, busy}, 32'd1);
        s_valid = 1'b0;
        wait_result("ign2", lat, ebl_cnt);
        chk("ign2_latency", lat, SC - 1);
        check_result("ign2", 16'h0002, 1'b0);
        @(negedge clk);

        // Reset mid-SETTLE when cnt has counted down to 10
        do_accept(16'h1111, 16'h2222);
        repeat (24) @(negedge clk);
        chk("pre_reset_ebl", {31'b0, add_ebl}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {28'b0, add_ebl, m_valid, busy, s_ready}, 32'd1);
        chk("midrst_ops", {add_a, add_b}, 32'd0);
        chk("midrst_result", {15'b0, m_carry, m_sum}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_valid || busy) seen++;
        end
        chk("midrst_no_result", seen, 0);
        do_accept(16'h8000, 16'h8000);
        wait_result("post_rst", lat, ebl_cnt);
        chk("post_rst_latency", lat, SC);
        check_result("post_rst", 16'h0000, 1'b1);
        @(negedge clk);

        // Back-to-back with s_valid and m_ready high
        begin
            logic [DW-1:0] pa [3];
            logic [DW-1:0] pb [3];
            logic [DW-1:0] ps [3];
            logic          pc [3];
            int            acc_cyc [3];
            int            n_acc, n_res;
            pa[0] = 16'h0F0F; pb[0] = 16'hF0F1; ps[0] = 16'h0000; pc[0] = 1'b1;
            pa[1] = 16'h7FFF; pb[1] = 16'h0001; ps[1] = 16'h8000; pc[1] = 1'b0;
            pa[2] = 16'hABCD; pb[2] = 16'h1111; ps[2] = 16'hBCDE; pc[2] = 1'b0;
            n_acc = 0;
            n_res = 0;
            acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
            for (int cyc = 0; cyc < 200 && n_res < 3; cyc++) begin
                @(negedge clk);
                if (m_valid) begin
                    chk("b2b_sum", {16'b0, m_sum}, {16'b0, ps[n_res]});
                    chk("b2b_carry", {31'b0, m_carry}, {31'b0, pc[n_res]});
                    n_res++;
                end
                s_valid = (n_acc < 3);
                if (n_acc < 3) begin
                    s_a = pa[n_acc];
                    s_b = pb[n_acc];
                end
                if (s_ready && s_valid) begin
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
            end
            s_valid = 1'b0;
            chk("b2b_results", n_res, 3);
            chk("b2b_spacing_01", acc_cyc[1] - acc_cyc[0], SC + 2);
            chk("b2b_spacing_12", acc_cyc[2] - acc_cyc[1], SC + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
